// File: rtl/apb_master.sv
// -----------------------------------------------------------------------------
// apb_master
//
// APB requester. Accepts one command at a time on a valid/ready command port,
// runs it as a single SETUP/ACCESS transfer on the APB bus, waits for PREADY
// with an optional bounded timeout, and reports completion on a one-cycle
// response strobe.
//
// Parameters
//   ADDR_W   width of PADDR / cmd_addr
//   DATA_W   width of PWDATA / PRDATA / cmd_wdata / rsp_rdata
//   TIMEOUT  ACCESS cycles without PREADY before abort (0 = never abort)
//
// Ports
//   PCLK         clock, rising edge
//   PRESET       synchronous reset, active-high
//   cmd_valid    command request
//   cmd_ready    command accepted on cmd_valid && cmd_ready at an edge
//   cmd_write    1 = write, 0 = read
//   cmd_addr     target address
//   cmd_wdata    write data
//   rsp_valid    one-cycle completion strobe
//   rsp_rdata    captured read data (0 for writes and timeouts)
//   rsp_timeout  1 = transfer aborted by timeout (qualified by rsp_valid)
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA  APB request outputs (registered)
//   PRDATA/PREADY                     APB completer inputs
// -----------------------------------------------------------------------------
module apb_master #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_timeout,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY
);

    // A zero TIMEOUT still needs a legal (1-bit) counter; it is never compared.
    localparam int             CNT_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);
    localparam logic           TO_EN     = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;

    logic                r_psel;
    logic                r_penable;
    logic                r_pwrite;
    logic [ADDR_W-1:0]   r_paddr;
    logic [DATA_W-1:0]   r_pwdata;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic                r_rsp_timeout;

    logic                w_psel_nxt;
    logic                w_penable_nxt;
    logic                w_pwrite_nxt;
    logic [ADDR_W-1:0]   w_paddr_nxt;
    logic [DATA_W-1:0]   w_pwdata_nxt;
    logic                w_rsp_valid_nxt;
    logic [DATA_W-1:0]   w_rsp_rdata_nxt;
    logic                w_rsp_timeout_nxt;

    logic                w_accept;
    logic                w_done;
    logic                w_abort;

    // Ready only in IDLE, and never while reset is being applied.
    assign cmd_ready = (r_state == ST_IDLE) && !PRESET;
    assign w_accept  = cmd_valid && cmd_ready;
    assign w_done    = (r_state == ST_ACCESS) && PREADY;
    // The counter holds the number of PREADY-low ACCESS cycles already seen,
    // so the abort fires on the (TIMEOUT+1)-th ACCESS cycle still without PREADY.
    assign w_abort   = (r_state == ST_ACCESS) && !PREADY && TO_EN && (r_cnt == CNT_LIMIT);

    // State register.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_SETUP;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SETUP: begin
                w_state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (w_done || w_abort) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_ACCESS;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output logic: next values for every registered output and the wait counter.
    always_comb begin
        // APB strobes follow the state being entered, so they are registered
        // alongside the state rather than decoded from it.
        w_psel_nxt        = (w_state_nxt != ST_IDLE);
        w_penable_nxt     = (w_state_nxt == ST_ACCESS);
        w_pwrite_nxt      = r_pwrite;
        w_paddr_nxt       = r_paddr;
        w_pwdata_nxt      = r_pwdata;
        w_rsp_valid_nxt   = w_done || w_abort;
        w_rsp_rdata_nxt   = r_rsp_rdata;
        w_rsp_timeout_nxt = r_rsp_timeout;
        w_cnt_nxt         = r_cnt;

        if (w_accept) begin
            // PWDATA is loaded even for reads; the completer ignores it.
            w_pwrite_nxt = cmd_write;
            w_paddr_nxt  = cmd_addr;
            w_pwdata_nxt = cmd_wdata;
            w_cnt_nxt    = {CNT_W{1'b0}};
        end else if ((r_state == ST_ACCESS) && !PREADY && !w_abort) begin
            if (r_cnt != CNT_MAX) begin
                w_cnt_nxt = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                w_cnt_nxt = r_cnt;
            end
        end else begin
            w_cnt_nxt = r_cnt;
        end

        if (w_done) begin
            w_rsp_rdata_nxt   = r_pwrite ? {DATA_W{1'b0}} : PRDATA;
            w_rsp_timeout_nxt = 1'b0;
        end else if (w_abort) begin
            w_rsp_rdata_nxt   = {DATA_W{1'b0}};
            w_rsp_timeout_nxt = 1'b1;
        end else begin
            w_rsp_rdata_nxt   = r_rsp_rdata;
            w_rsp_timeout_nxt = r_rsp_timeout;
        end
    end

    // Output and counter registers.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_pwrite      <= 1'b0;
            r_paddr       <= {ADDR_W{1'b0}};
            r_pwdata      <= {DATA_W{1'b0}};
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= {DATA_W{1'b0}};
            r_rsp_timeout <= 1'b0;
            r_cnt         <= {CNT_W{1'b0}};
        end else begin
            r_psel        <= w_psel_nxt;
            r_penable     <= w_penable_nxt;
            r_pwrite      <= w_pwrite_nxt;
            r_paddr       <= w_paddr_nxt;
            r_pwdata      <= w_pwdata_nxt;
            r_rsp_valid   <= w_rsp_valid_nxt;
            r_rsp_rdata   <= w_rsp_rdata_nxt;
            r_rsp_timeout <= w_rsp_timeout_nxt;
            r_cnt         <= w_cnt_nxt;
        end
    end

    assign PSEL        = r_psel;
    assign PENABLE     = r_penable;
    assign PWRITE      = r_pwrite;
    assign PADDR       = r_paddr;
    assign PWDATA      = r_pwdata;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_timeout = r_rsp_timeout;

endmodule

// File: tb/tb_apb_master.sv
// -----------------------------------------------------------------------------
// tb_apb_master
//
// Self-checking bench for apb_master. A driver issues commands; at each accept
// the expected response (data, timeout flag, latency) is pushed into a queue by
// a reference model of an operand/result register peripheral. A monitor pops
// and compares on every rsp_valid. A small APB completer with per-transfer
// wait states plays the peripheral on the bus side.
// -----------------------------------------------------------------------------
module tb_apb_master;

    localparam int TIMEOUT = 16;

    logic        PCLK;
    logic        PRESET;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_timeout;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;

    apb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge PCLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model (register peripheral) ----------------
    // 0x0 op1, 0x4 op2, 0x8 result (read-only), 0xC control, other: scratch.
    // control[1:0]: 1 = op1 & op2, 2 = op1 | op2, 3 = op1 ^ op2, 0 = zero.
    logic [31:0] ref_mem [logic [31:0]];

    function automatic logic [31:0] ref_get(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return 32'h0;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        logic [31:0] o1, o2, c;
        if (a != 32'h8) return ref_get(a);
        o1 = ref_get(32'h0);
        o2 = ref_get(32'h4);
        c  = ref_get(32'hC);
        if (c[1:0] == 2'd1) return o1 & o2;
        if (c[1:0] == 2'd2) return o1 | o2;
        if (c[1:0] == 2'd3) return o1 ^ o2;
        return 32'h0;
    endfunction

    function automatic void ref_write(input logic [31:0] a, input logic [31:0] d);
        if (a != 32'h8) ref_mem[a] = d;
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [31:0] rdata;
        logic        to;
        int          acc;
        int          lat;
    } exp_t;
    exp_t sb_q[$];

    // Driver-published current transfer, used by the completer and bus checker.
    int          cur_wait  = 0;
    logic        exp_write = 1'b0;
    logic [31:0] exp_addr  = 32'h0;
    logic [31:0] exp_wdata = 32'h0;

    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input int wt, output int acc_cyc);
        int   budget;
        exp_t e;
        budget    = 0;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        while (!cmd_ready && budget < 200) begin
            @(negedge PCLK);
            budget++;
        end
        if (!cmd_ready) begin
            chk("accept_wait", 32'(cmd_ready), 32'h1);
            cmd_valid = 1'b0;
            acc_cyc   = -1;
            return;
        end
        acc_cyc   = cyc;
        cur_wait  = wt;
        exp_write = w;
        exp_addr  = a;
        exp_wdata = d;
        e.acc     = cyc;
        e.to      = (wt > TIMEOUT);
        e.lat     = e.to ? (TIMEOUT + 3) : (wt + 3);
        if (e.to || w) e.rdata = 32'h0;
        else           e.rdata = ref_read(a);
        if (!e.to && w) ref_write(a, d);
        sb_q.push_back(e);
        @(negedge PCLK);
    endtask

    task automatic idle(input int n);
        cmd_valid = 1'b0;
        repeat (n) @(negedge PCLK);
    endtask

    // ---------------- APB completer ----------------
    logic [31:0] per_mem [logic [31:0]];

    function automatic logic [31:0] per_word(input logic [31:0] a);
        return per_mem.exists(a) ? per_mem[a] : 32'h0;
    endfunction

    initial begin : completer
        int acc_idx;
        logic [31:0] x;
        acc_idx = 0;
        PREADY  = 1'b0;
        PRDATA  = 32'h0;
        forever begin
            @(negedge PCLK);
            if (PSEL && PENABLE && !PRESET) begin
                PRDATA = $urandom;
                if (acc_idx == cur_wait) begin
                    PREADY = 1'b1;
                    if (PWRITE) begin
                        if (PADDR != 32'h8) per_mem[PADDR] = PWDATA;
                    end else if (PADDR == 32'h8) begin
                        x = per_word(32'hC);
                        case (x[1:0])
                            2'd1:    PRDATA = per_word(32'h0) & per_word(32'h4);
                            2'd2:    PRDATA = per_word(32'h0) | per_word(32'h4);
                            2'd3:    PRDATA = per_word(32'h0) ^ per_word(32'h4);
                            default: PRDATA = 32'h0;
                        endcase
                    end else begin
                        PRDATA = per_word(PADDR);
                    end
                end else begin
                    PREADY = 1'b0;
                end
                acc_idx++;
            end else begin
                // Outside ACCESS, PREADY/PRDATA are noise the master must ignore.
                PREADY = 1'($urandom_range(0, 1));
                PRDATA = $urandom;
                if (PSEL) acc_idx = 0;
            end
        end
    end

    // ---------------- response monitor ----------------
    always @(negedge PCLK) begin
        exp_t e;
        if (!PRESET && rsp_valid) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_rsp", 32'(rsp_valid), 32'h0);
            end else begin
                e = sb_q.pop_front();
                chk("rsp_rdata",   rsp_rdata,          e.rdata);
                chk("rsp_timeout", 32'(rsp_timeout),   32'(e.to));
                chk("rsp_latency", 32'(cyc - e.acc),   32'(e.lat));
                chk("psel_in_rsp", 32'(PSEL),          32'h0);
            end
        end
    end

    // ---------------- APB bus checker ----------------
    logic prev_psel = 1'b0;
    always @(negedge PCLK) begin
        if (!PRESET) begin
            if (PSEL) begin
                chk("penable_phase", 32'(PENABLE), 32'(prev_psel));
                chk("paddr_stable",  PADDR,        exp_addr);
                chk("pwrite_stable", 32'(PWRITE),  32'(exp_write));
                chk("pwdata_stable", PWDATA,       exp_wdata);
            end
            prev_psel <= PSEL;
        end else begin
            prev_psel <= 1'b0;
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    // ---------------- main stimulus ----------------
    initial begin
        int a0, a1, a2, a3;
        int wt;
        logic [31:0] ra;
        PRESET    = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 32'h0;
        cmd_wdata = 32'h0;
        repeat (3) @(negedge PCLK);

        // Reset state.
        chk("rst_cmd_ready",   32'(cmd_ready),   32'h0);
        chk("rst_psel",        32'(PSEL),        32'h0);
        chk("rst_penable",     32'(PENABLE),     32'h0);
        chk("rst_pwrite",      32'(PWRITE),      32'h0);
        chk("rst_paddr",       PADDR,            32'h0);
        chk("rst_pwdata",      PWDATA,           32'h0);
        chk("rst_rsp_valid",   32'(rsp_valid),   32'h0);
        chk("rst_rsp_rdata",   rsp_rdata,        32'h0);
        chk("rst_rsp_timeout", 32'(rsp_timeout), 32'h0);
        PRESET = 1'b0;
        #1;
        chk("post_rst_ready", 32'(cmd_ready), 32'h1);
        @(negedge PCLK);

        // Zero-wait write, then the operand/result sequence.
        issue(1'b1, 32'h0, 32'h0000_00F0, 0, a0);
        idle(3);
        issue(1'b1, 32'h0, 32'h0000_00FF, 0, a0);
        issue(1'b1, 32'h4, 32'h0000_000F, 1, a0);
        issue(1'b1, 32'hC, 32'h0000_0001, 0, a0);
        issue(1'b0, 32'h8, 32'h0,         0, a0);
        issue(1'b1, 32'hC, 32'h0000_0003, 0, a0);
        issue(1'b0, 32'h8, 32'h0,         0, a0);
        idle(4);

        // Read 0x8 with two wait states, yielding 0x30.
        issue(1'b1, 32'h0, 32'h0000_0030, 0, a0);
        issue(1'b1, 32'h4, 32'h0000_0030, 0, a0);
        issue(1'b1, 32'hC, 32'h0000_0001, 0, a0);
        issue(1'b0, 32'h8, 32'hDEAD_BEEF, 2, a0);
        idle(6);

        // Timeout, then a command accepted in the response cycle.
        issue(1'b0, 32'h4, 32'h0, 1000, a0);
        issue(1'b1, 32'h10, 32'h1234_5678, 0, a1);
        chk("accept_after_timeout", 32'(a1 - a0), 32'(TIMEOUT + 3));
        // Boundaries: PREADY on the last allowed cycle and one before it.
        issue(1'b0, 32'h10, 32'h0, TIMEOUT, a0);
        issue(1'b0, 32'h0, 32'h0, TIMEOUT - 1, a0);
        idle(5);

        // Back-to-back with cmd_valid held high.
        issue(1'b1, 32'h14, 32'hA5A5_0001, 0, a0);
        issue(1'b0, 32'h14, 32'h0,         0, a1);
        issue(1'b1, 32'h10, 32'h5A5A_0002, 0, a2);
        issue(1'b0, 32'h10, 32'h0,         0, a3);
        chk("b2b_spacing_1", 32'(a1 - a0), 32'd3);
        chk("b2b_spacing_2", 32'(a2 - a1), 32'd3);
        chk("b2b_spacing_3", 32'(a3 - a2), 32'd3);
        idle(5);

        // Reset in the middle of ACCESS.
        issue(1'b0, 32'h4, 32'h0, 5, a0);
        cmd_valid = 1'b0;
        @(negedge PCLK);
        chk("pre_rst_access", 32'(PSEL && PENABLE), 32'h1);
        PRESET = 1'b1;
        void'(sb_q.pop_back());
        @(negedge PCLK);
        chk("mid_rst_psel",      32'(PSEL),      32'h0);
        chk("mid_rst_penable",   32'(PENABLE),   32'h0);
        chk("mid_rst_paddr",     PADDR,          32'h0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("mid_rst_rsp_rdata", rsp_rdata,      32'h0);
        chk("mid_rst_ready",     32'(cmd_ready), 32'h0);
        PRESET = 1'b0;
        #1;
        chk("mid_rst_ready_after", 32'(cmd_ready), 32'h1);
        @(negedge PCLK);

        // Randomized traffic.
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 5))
                0:       ra = 32'h0;
                1:       ra = 32'h4;
                2:       ra = 32'h8;
                3:       ra = 32'hC;
                4:       ra = 32'h10;
                default: ra = 32'h14;
            endcase
            wt = ($urandom_range(0, 9) == 0) ? 100 : $urandom_range(0, 3);
            issue(1'($urandom_range(0, 1)), ra, $urandom, wt, a0);
            idle($urandom_range(0, 2));
        end

        idle(TIMEOUT + 10);
        chk("scoreboard_drained", 32'(sb_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
